instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 58 +++++
 rtl/instr_encoder_pack.sv | 40 ++++
 rtl/instr_encoder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared constants and types for the instruction encoder:
//                op enum, opcode/funct values, memory window and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    localparam int CNT_W = 13;

    localparam logic [31:0]      IM_BASE  = 32'h0000_3000;
    localparam logic [CNT_W-1:0] IM_WORDS = 13'd4096;
    localparam logic [CNT_W-1:0] IM_LAST  = IM_WORDS - 13'd1;

    // Request operation codes; 9..15 are illegal
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ORI = 4'd2,
        OP_LW  = 4'd3,
        OP_SW  = 4'd4,
        OP_BEQ = 4'd5,
        OP_LUI = 4'd6,
        OP_JAL = 4'd7,
        OP_JR  = 4'd8
    } op_e;

    // Primary opcodes, identical to the controller decode values
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_JAL   = 6'h03;

    // R-type function fields
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    // Common I-type layout shared by ORI/LW/SW/BEQ
    function automatic logic [31:0] pack_itype(input logic [5:0]  opc,
                                               input logic [4:0]  rs,
                                               input logic [4:0]  rt,
                                               input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// ============================================================================
//  Module      : instr_pack
//  Description : Combinational encoder: op + register/immediate fields in,
//                32-bit instruction word and illegal-op flag out.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Select the encoding for the requested op; unknown ops flag illegal
    always_comb begin
        word_o    = 32'h0000_0000;
        illegal_o = 1'b0;
        case (op_i)
            OP_ADD:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'h00, FN_ADD};
            OP_SUB:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'h00, FN_SUB};
            OP_ORI:  word_o = pack_itype(OPC_ORI, rs_i, rt_i, imm_i);
            OP_LW:   word_o = pack_itype(OPC_LW,  rs_i, rt_i, imm_i);
            OP_SW:   word_o = pack_itype(OPC_SW,  rs_i, rt_i, imm_i);
            OP_BEQ:  word_o = pack_itype(OPC_BEQ, rs_i, rt_i, imm_i);
            OP_LUI:  word_o = pack_itype(OPC_LUI, 5'h00, rt_i, imm_i);
            OP_JAL:  word_o = {OPC_JAL, target_i};
            OP_JR:   word_o = {OPC_RTYPE, rs_i, 15'h0000, FN_JR};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Accepts encode requests, packs them into instruction words
//                and streams them into instruction memory starting at
//                IM_BASE, one word per cycle, until IM_WORDS are written.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    input  logic              im_ready,
    output logic [31:0]       im_addr,
    output logic [31:0]       im_wdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              err
);

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        addr_q,  addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q,   err_d;

    logic [31:0]        pk_word;
    logic               pk_illegal;
    logic               drain;
    logic               accept;
    logic               room;
    logic [CNT_W-1:0]   occupancy;

    instr_pack u_pack (
        .op_i      (op),
        .rs_i      (rs),
        .rt_i      (rt),
        .rd_i      (rd),
        .imm_i     (imm),
        .target_i  (target),
        .word_o    (pk_word),
        .illegal_o (pk_illegal)
    );

    // A word still in the output register counts against the memory window
    assign drain     = valid_q & im_ready;
    assign occupancy = count_q + {{(CNT_W-1){1'b0}}, valid_q};
    assign room      = (occupancy < IM_WORDS);
    assign accept    = in_valid & in_ready;

    // Next state and request handshake; start overrides everything
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN: begin
                in_ready = ~start & (~valid_q | drain) & room;
                if (drain && (count_q == IM_LAST)) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: state_d = ST_FULL;
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_RUN;
        end
    end

    // Output register, address/count bookkeeping and sticky error
    always_comb begin
        valid_d = valid_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        if (start) begin
            valid_d = 1'b0;
            addr_d  = IM_BASE;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (drain) begin
                valid_d = 1'b0;
                addr_d  = addr_q + 32'd4;
                count_d = count_q + 13'd1;
            end
            if (accept) begin
                if (pk_illegal) begin
                    err_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    wdata_d = pk_word;
                end
            end
        end
    end

    // State and datapath registers; reset clears the pending word at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            wdata_q <= 32'h0000_0000;
            addr_q  <= IM_BASE;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign im_we    = valid_q;
    assign im_wdata = wdata_q;
    assign im_addr  = addr_q;
    assign count    = count_q;
    assign full     = (state_q == ST_FULL);
    assign err      = err_q;

endmodule
`default_nettype wire
